mips_multicycle_core: RTL



---
 rtl/mips_multicycle_core.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core (add/sub/and/or/slt/lw/sw/beq/j/addi) with a single
// req/ready memory port, configurable unknown-opcode handling and a retire pulse.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter bit          STRICT_DECODE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        instr_retired,
   output logic        halted,
   output logic [31:0] t0,
   output logic [31:0] t1,
   output logic [31:0] t2,
   output logic [31:0] t3,
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC     = 4'd2,
      S_ALUWB    = 4'd3,
      S_MEMADR   = 4'd4,
      S_MEMREAD  = 4'd5,
      S_MEMWB    = 4'd6,
      S_MEMWRITE = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDIEXEC = 4'd10,
      S_ADDIWB   = 4'd11,
      S_HALT     = 4'd12
   } state_t;

   state_t      state_r, state_s;
   logic [31:0] pc_r, ir_r, a_r, b_r, aluout_r, mdr_r;
   logic [31:0] rf_r [0:31];

   logic [5:0]  opcode_s, funct_s;
   logic [4:0]  rs_s, rt_s, rd_s;
   logic [31:0] sext_imm_s, rs_val_s, rt_val_s, alu_s, rf_wdata_s;
   logic        funct_ok_s, mem_done_s, rf_we_s;
   logic [4:0]  rf_waddr_s;

   assign opcode_s   = ir_r[31:26];
   assign rs_s       = ir_r[25:21];
   assign rt_s       = ir_r[20:16];
   assign rd_s       = ir_r[15:11];
   assign funct_s    = ir_r[5:0];
   assign sext_imm_s = {{16{ir_r[15]}}, ir_r[15:0]};
   assign rs_val_s   = (rs_s == 5'd0) ? 32'h0000_0000 : rf_r[rs_s];
   assign rt_val_s   = (rt_s == 5'd0) ? 32'h0000_0000 : rf_r[rt_s];

   // Port signals decode straight from the state register; reset kills the request at once.
   assign mem_req    = ~reset & ((state_r == S_FETCH) | (state_r == S_MEMREAD) | (state_r == S_MEMWRITE));
   assign mem_we     = (state_r == S_MEMWRITE);
   assign mem_addr   = {((state_r == S_FETCH) ? pc_r[31:2] : aluout_r[31:2]), 2'b00};
   assign mem_wdata  = b_r;
   assign mem_done_s = mem_req & mem_ready;
   assign halted     = (state_r == S_HALT);
   assign state_dbg  = state_r;
   assign t0         = rf_r[8];
   assign t1         = rf_r[9];
   assign t2         = rf_r[10];
   assign t3         = rf_r[11];

   // R-type ALU; flags funct codes outside the supported set.
   always_comb begin
      alu_s      = 32'h0000_0000;
      funct_ok_s = 1'b1;
      case (funct_s)
         6'h20:   alu_s = a_r + b_r;
         6'h22:   alu_s = a_r - b_r;
         6'h24:   alu_s = a_r & b_r;
         6'h25:   alu_s = a_r | b_r;
         6'h2A:   alu_s = {31'h0000_0000, ($signed(a_r) < $signed(b_r))};
         default: funct_ok_s = 1'b0;
      endcase
   end

   // Next-state, retire pulse and register-file write control.
   always_comb begin
      state_s       = state_r;
      instr_retired = 1'b0;
      rf_we_s       = 1'b0;
      rf_waddr_s    = rt_s;
      rf_wdata_s    = aluout_r;
      case (state_r)
         S_FETCH: begin
            if (mem_done_s) state_s = S_DECODE;
            else            state_s = S_FETCH;
         end
         S_DECODE: begin
            case (opcode_s)
               6'h00:        state_s = S_EXEC;
               6'h23, 6'h2B: state_s = S_MEMADR;
               6'h04:        state_s = S_BRANCH;
               6'h02:        state_s = S_JUMP;
               6'h08:        state_s = S_ADDIEXEC;
               default: begin
                  if (STRICT_DECODE == 1'b1) begin
                     state_s = S_HALT;
                  end else begin
                     state_s       = S_FETCH;
                     instr_retired = 1'b1;
                  end
               end
            endcase
         end
         S_EXEC: begin
            if (funct_ok_s) begin
               state_s = S_ALUWB;
            end else if (STRICT_DECODE == 1'b1) begin
               state_s = S_HALT;
            end else begin
               state_s       = S_FETCH;
               instr_retired = 1'b1;
            end
         end
         S_ALUWB: begin
            rf_we_s       = 1'b1;
            rf_waddr_s    = rd_s;
            instr_retired = 1'b1;
            state_s       = S_FETCH;
         end
         S_MEMADR: begin
            if (opcode_s == 6'h23) state_s = S_MEMREAD;
            else                   state_s = S_MEMWRITE;
         end
         S_MEMREAD: begin
            if (mem_done_s) state_s = S_MEMWB;
            else            state_s = S_MEMREAD;
         end
         S_MEMWB: begin
            rf_we_s       = 1'b1;
            rf_wdata_s    = mdr_r;
            instr_retired = 1'b1;
            state_s       = S_FETCH;
         end
         S_MEMWRITE: begin
            if (mem_done_s) begin
               instr_retired = 1'b1;
               state_s       = S_FETCH;
            end else begin
               state_s = S_MEMWRITE;
            end
         end
         S_BRANCH, S_JUMP: begin
            instr_retired = 1'b1;
            state_s       = S_FETCH;
         end
         S_ADDIEXEC: state_s = S_ADDIWB;
         S_ADDIWB: begin
            rf_we_s       = 1'b1;
            instr_retired = 1'b1;
            state_s       = S_FETCH;
         end
         S_HALT:  state_s = S_HALT;
         default: state_s = S_HALT;
      endcase
   end

   // State register and multicycle datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= S_FETCH;
         pc_r     <= RESET_PC;
         ir_r     <= 32'h0000_0000;
         a_r      <= 32'h0000_0000;
         b_r      <= 32'h0000_0000;
         aluout_r <= 32'h0000_0000;
         mdr_r    <= 32'h0000_0000;
      end else begin
         state_r <= state_s;
         case (state_r)
            S_FETCH: begin
               if (mem_done_s) begin
                  ir_r <= mem_rdata;
                  pc_r <= pc_r + 32'd4;
               end
            end
            S_DECODE: begin
               a_r      <= rs_val_s;
               b_r      <= rt_val_s;
               aluout_r <= pc_r + {sext_imm_s[29:0], 2'b00};
            end
            S_EXEC:               aluout_r <= alu_s;
            S_MEMADR, S_ADDIEXEC: aluout_r <= a_r + sext_imm_s;
            S_MEMREAD: begin
               if (mem_done_s) mdr_r <= mem_rdata;
            end
            S_BRANCH: begin
               if (a_r == b_r) pc_r <= aluout_r;
            end
            S_JUMP:  pc_r <= {pc_r[31:28], ir_r[25:0], 2'b00};
            default: ;
         endcase
      end
   end

   // General-purpose register file; r0 is never written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_r[i] <= 32'h0000_0000;
      end else if (rf_we_s && (rf_waddr_s != 5'd0)) begin
         rf_r[rf_waddr_s] <= rf_wdata_s;
      end
   end

endmodule
